// File: rtl/comp_dispatch_arbiter_pkg.sv
// Shared types for the compression dispatch arbiter: core index width and
// input-side FSM states.
package comp_arb_pkg;

  localparam int COMP_MAX_CORES = 16;

  typedef logic [3:0] core_idx_t;

  typedef enum logic {
    IDLE,
    BUSY
  } in_state_t;

  // Next core after idx, wrapping to 0 after core n-1.
  function automatic core_idx_t wrap_inc(core_idx_t idx, int n);
    return (int'(idx) == n - 1) ? core_idx_t'(0) : idx + core_idx_t'(1);
  endfunction

endpackage

// File: rtl/comp_dispatch_arbiter_order_fifo.sv
// Order FIFO: remembers which core received each frame so results can be
// returned to the host in arrival order.
module order_fifo
  import comp_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  core_idx_t push_idx,
  input  logic      pop,
  output core_idx_t head_idx,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  core_idx_t   mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_idx = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees the slot the push lands in, so full is no obstacle then.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_idx;
  end

endmodule

// File: rtl/comp_dispatch_arbiter.sv
// Frame dispatcher: sends whole host frames to any free compression core and
// returns results in arrival order. `DISPATCH_STATS_EN adds frame/stall counters.
//
//   state | meaning
//   IDLE  | waiting for a frame and a core with a free slot; pick core
//   BUSY  | streaming the current frame to core sel_in
module comp_dispatch_arbiter
  import comp_arb_pkg::*;
#(
  parameter int N_CORES     = 4,
  parameter int DATA_BITS   = 512,
  parameter int CORE_SLOTS  = 2,
  parameter int ORDER_DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_BITS-1:0]           s_tdata,
  input  logic [DATA_BITS/8-1:0]         s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [N_CORES*DATA_BITS-1:0]   c_in_tdata,
  output logic [N_CORES*DATA_BITS/8-1:0] c_in_tkeep,
  output logic [N_CORES-1:0]             c_in_tlast,
  output logic [N_CORES-1:0]             c_in_tvalid,
  input  logic [N_CORES-1:0]             c_in_tready,
  input  logic [N_CORES*DATA_BITS-1:0]   c_out_tdata,
  input  logic [N_CORES*DATA_BITS/8-1:0] c_out_tkeep,
  input  logic [N_CORES-1:0]             c_out_tlast,
  input  logic [N_CORES-1:0]             c_out_tvalid,
  output logic [N_CORES-1:0]             c_out_tready,
  output logic [DATA_BITS-1:0]           m_tdata,
  output logic [DATA_BITS/8-1:0]         m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [5:0]                     m_tid
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                    frames_in,
  output logic [31:0]                    frames_out,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int KW = DATA_BITS / 8;
  localparam int CW = $clog2(CORE_SLOTS + 1);

  in_state_t          state;
  core_idx_t          sel_in;
  core_idx_t          rr_ptr;
  core_idx_t          pick;
  core_idx_t          sel_out;
  logic               first_beat;
  logic [CW-1:0]      inflight [N_CORES];
  logic [N_CORES-1:0] elig;
  logic [N_CORES-1:0] inc;
  logic [N_CORES-1:0] dec;
  logic               any_elig;
  logic               fifo_full;
  logic               fifo_empty;
  logic               in_hs;
  logic               push;
  logic               pop;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) elig[i] = (inflight[i] < CW'(CORE_SLOTS));
  end

  // First eligible core scanning upward from rr_ptr.
  always_comb begin
    pick     = '0;
    any_elig = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (!any_elig && elig[i] && (i == (int'(rr_ptr) + k) % N_CORES)) begin
          pick     = core_idx_t'(i);
          any_elig = 1'b1;
        end
      end
    end
  end

  always_comb begin
    c_in_tvalid = '0;
    s_tready    = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      if (state == BUSY && sel_in == core_idx_t'(i)) begin
        c_in_tvalid[i] = s_tvalid;
        s_tready       = c_in_tready[i];
      end
    end
  end

  assign c_in_tdata = {N_CORES{s_tdata}};
  assign c_in_tkeep = {N_CORES{s_tkeep}};
  assign c_in_tlast = {N_CORES{s_tlast}};
  assign in_hs      = s_tvalid && s_tready;
  assign push       = in_hs && first_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel_in     <= '0;
      rr_ptr     <= '0;
      first_beat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_tvalid && any_elig && !fifo_full) begin
            sel_in     <= pick;
            first_beat <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (in_hs) begin
            first_beat <= 1'b0;
            if (s_tlast) begin
              rr_ptr <= wrap_inc(sel_in, N_CORES);
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  order_fifo #(
    .DEPTH(ORDER_DEPTH)
  ) u_order_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_idx (sel_in),
    .pop      (pop),
    .head_idx (sel_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tvalid     = 1'b0;
    c_out_tready = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (!fifo_empty && sel_out == core_idx_t'(i)) begin
        m_tdata         = c_out_tdata[i*DATA_BITS +: DATA_BITS];
        m_tkeep         = c_out_tkeep[i*KW +: KW];
        m_tlast         = c_out_tlast[i];
        m_tvalid        = c_out_tvalid[i];
        c_out_tready[i] = m_tready;
      end
    end
  end

  assign pop   = m_tvalid && m_tready && m_tlast;
  assign m_tid = '0;

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      inc[i] = push && (sel_in == core_idx_t'(i));
      dec[i] = pop && (sel_out == core_idx_t'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CORES; i++) inflight[i] <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        if (inc[i] && !dec[i])      inflight[i] <= inflight[i] + CW'(1);
        else if (dec[i] && !inc[i]) inflight[i] <= inflight[i] - CW'(1);
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames_in    <= '0;
      frames_out   <= '0;
      stall_cycles <= '0;
    end else begin
      if (in_hs && s_tlast) frames_in <= frames_in + 32'd1;
      if (pop)              frames_out <= frames_out + 32'd1;
      if (state == IDLE && s_tvalid && (!any_elig || fifo_full))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
